cpu_cu: RTL

CPU_CU -- requirements
Module: cpu_cu

---
 rtl/cpu_pkg.sv | 75 +++++++
 rtl/cpu_cu_decode.sv | 42 ++++
 rtl/cpu_cu.sv | 103 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: state encodings, instruction class codes,
// strobe bit positions and the per-state strobe decode.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC_ALU = 3'd3,
        ST_EXEC_LD  = 3'd4,
        ST_EXEC_ST  = 3'd5,
        ST_EXEC_BR  = 3'd6,
        ST_HALT     = 3'd7
    } cu_state_e;

    // Instruction class, taken from ir[11:9].
    typedef enum logic [2:0] {
        CLS_ALU  = 3'b000,
        CLS_LD   = 3'b001,
        CLS_ST   = 3'b010,
        CLS_BR   = 3'b011,
        CLS_BRZ  = 3'b100,
        CLS_BRN  = 3'b101,
        CLS_BRC  = 3'b110,
        CLS_HALT = 3'b111
    } cls_e;

    localparam int STB_W       = 8;
    localparam int STB_W_EN    = 0;
    localparam int STB_S_SEL   = 1;
    localparam int STB_PC_LD   = 2;
    localparam int STB_PC_INC  = 3;
    localparam int STB_IR_LD   = 4;
    localparam int STB_ADR_SEL = 5;
    localparam int STB_MR_EN   = 6;
    localparam int STB_MW_EN   = 7;

    // Strobes owned by each state. The pc_ld bit only arms the branch;
    // the condition is applied in the EXEC_BR cycle itself.
    function automatic logic [STB_W-1:0] state_strobes(input cu_state_e s);
        logic [STB_W-1:0] v;
        v = '0;
        unique case (s)
            ST_FETCH: begin
                v[STB_MR_EN]  = 1'b1;
                v[STB_IR_LD]  = 1'b1;
                v[STB_PC_INC] = 1'b1;
            end
            ST_EXEC_ALU: begin
                v[STB_W_EN] = 1'b1;
            end
            ST_EXEC_LD: begin
                v[STB_ADR_SEL] = 1'b1;
                v[STB_MR_EN]   = 1'b1;
                v[STB_S_SEL]   = 1'b1;
                v[STB_W_EN]    = 1'b1;
            end
            ST_EXEC_ST: begin
                v[STB_ADR_SEL] = 1'b1;
                v[STB_MW_EN]   = 1'b1;
            end
            ST_EXEC_BR: begin
                v[STB_PC_LD] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic is_exec(input cu_state_e s);
        return (s == ST_EXEC_ALU) || (s == ST_EXEC_LD) ||
               (s == ST_EXEC_ST)  || (s == ST_EXEC_BR);
    endfunction

endpackage

// File: rtl/cpu_cu_decode.sv
// Class/condition decoder: maps ir[11:9] and the C/N/Z flags to the
// execute state to enter after DECODE and whether a branch is taken.
module cpu_cu_decode
    import cpu_pkg::*;
(
    input  logic [2:0] cls,
    input  logic       c,
    input  logic       n,
    input  logic       z,
    output cu_state_e  exec_state,
    output logic       br_taken
);

    always_comb begin
        exec_state = ST_HALT;
        br_taken   = 1'b0;
        unique case (cls)
            CLS_ALU:  exec_state = ST_EXEC_ALU;
            CLS_LD:   exec_state = ST_EXEC_LD;
            CLS_ST:   exec_state = ST_EXEC_ST;
            CLS_BR: begin
                exec_state = ST_EXEC_BR;
                br_taken   = 1'b1;
            end
            CLS_BRZ: begin
                exec_state = ST_EXEC_BR;
                br_taken   = z;
            end
            CLS_BRN: begin
                exec_state = ST_EXEC_BR;
                br_taken   = n;
            end
            CLS_BRC: begin
                exec_state = ST_EXEC_BR;
                br_taken   = c;
            end
            CLS_HALT: exec_state = ST_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// Multi-cycle CPU control unit: FETCH / DECODE / EXEC_* sequencer with
// registered execution-unit strobes and a retired-instruction counter.
// Ports: clk, reset (async, active-low), D_in (instruction word), C/N/Z
// flags; strobes w_en s_sel pc_ld pc_inc ir_ld adr_sel mr_en mw_en,
// halted, icnt (retired count) and state (debug).
module cpu_cu
    import cpu_pkg::*;
#(
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       D_in,
    input  logic              C,
    input  logic              N,
    input  logic              Z,
    output logic              w_en,
    output logic              s_sel,
    output logic              pc_ld,
    output logic              pc_inc,
    output logic              ir_ld,
    output logic              adr_sel,
    output logic              mr_en,
    output logic              mw_en,
    output logic              halted,
    output logic [ICNT_W-1:0] icnt,
    output logic [2:0]        state
);

    cu_state_e          state_q;
    cu_state_e          state_d;
    cu_state_e          exec_state;
    logic               br_taken;
    logic [STB_W-1:0]   strobe_q;
    logic [STB_W-1:0]   strobe_d;
    logic               halted_q;
    logic [15:0]        ir_q;
    logic [ICNT_W-1:0]  icnt_q;

    // Operand fields are consumed by the execution unit's own IR;
    // the full word is kept here for debug visibility.
    logic               ir_unused;
    assign ir_unused = ^{ir_q[15:12], ir_q[8:0]};

    cpu_cu_decode u_decode (
        .cls        (ir_q[11:9]),
        .c          (C),
        .n          (N),
        .z          (Z),
        .exec_state (exec_state),
        .br_taken   (br_taken)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RST:      state_d = ST_FETCH;
            ST_FETCH:    state_d = ST_DECODE;
            ST_DECODE:   state_d = exec_state;
            ST_EXEC_ALU,
            ST_EXEC_LD,
            ST_EXEC_ST,
            ST_EXEC_BR:  state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
        endcase
        // Strobes are computed from the next state and registered
        // alongside it, so each output comes straight from a flop.
        strobe_d = state_strobes(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RST;
            strobe_q <= '0;
            halted_q <= 1'b0;
            ir_q     <= 16'h0000;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            halted_q <= (state_d == ST_HALT);
            if (state_q == ST_FETCH)
                ir_q <= D_in;
            if (is_exec(state_q))
                icnt_q <= icnt_q + ICNT_W'(1);
        end
    end

    assign w_en    = strobe_q[STB_W_EN];
    assign s_sel   = strobe_q[STB_S_SEL];
    assign pc_inc  = strobe_q[STB_PC_INC];
    assign ir_ld   = strobe_q[STB_IR_LD];
    assign adr_sel = strobe_q[STB_ADR_SEL];
    assign mr_en   = strobe_q[STB_MR_EN];
    assign mw_en   = strobe_q[STB_MW_EN];
    // Flags are the execution unit's registered outputs, so they are
    // stable through the EXEC_BR cycle in which they are sampled.
    assign pc_ld   = strobe_q[STB_PC_LD] & br_taken;
    assign halted  = halted_q;
    assign icnt    = icnt_q;
    assign state   = state_q;

endmodule
